// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: owns the PC, captures imem words and
// hands them downstream; advances via the external incrementer or JNO.
module fetch_seq #(
  parameter int unsigned PC_W    = 2,
  parameter int unsigned INSTR_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  output logic [PC_W-1:0]    inc_prev,
  input  logic [PC_W-1:0]    inc_value,
  input  logic               inc_carry,
  input  logic               ovf_flag,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               wrapped,
  output logic               halted
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    HALT
  } state_t;

  localparam logic [1:0] OP_JNO = 2'b00;
  localparam logic [1:0] OP_HLT = 2'b11;

  state_t            state;
  logic [PC_W-1:0]   pc;
  logic [1:0]        opcode;
  logic [PC_W-1:0]   target;
  logic              accept;
  logic              do_halt;
  logic              do_jump;

  assign imem_addr = pc;
  assign inc_prev  = pc;

  assign opcode = instr_out[INSTR_W-1 -: 2];
  assign target = instr_out[PC_W-1:0];
  assign accept = (state == HOLD) && instr_ready;

  always_comb begin
    do_halt = 1'b0;
    do_jump = 1'b0;
    unique case (1'b1)
      (opcode == OP_HLT): do_halt = 1'b1;
      (opcode == OP_JNO): do_jump = !ovf_flag;
      default:            ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= '0;
      instr_out   <= '0;
      instr_valid <= 1'b0;
      wrapped     <= 1'b0;
      halted      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (run) state <= REQ;
        end
        REQ: begin
          if (imem_valid) begin
            instr_out   <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (accept) begin
            instr_valid <= 1'b0;
            if (do_halt) begin
              halted <= 1'b1;
              state  <= HALT;
            end else if (do_jump) begin
              // taken jumps never count as a wrap, even to address 0
              pc    <= target;
              state <= REQ;
            end else begin
              pc    <= inc_value;
              state <= REQ;
              if (inc_carry) wrapped <= 1'b1;
            end
          end
        end
        HALT: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_seq.sv
// Directed + random bench for fetch_seq with a spec-level PC model
// and an ideal incrementer driven from inc_prev.
module tb_fetch_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic [1:0] imem_addr;
  logic [7:0] imem_rdata = '0;
  logic       imem_valid = 1'b0;
  logic [1:0] inc_prev;
  logic [1:0] inc_value;
  logic       inc_carry;
  logic       ovf_flag = 1'b0;
  logic [7:0] instr_out;
  logic       instr_valid;
  logic       instr_ready = 1'b0;
  logic       wrapped;
  logic       halted;

  int checks = 0;
  int errors = 0;
  int m_pc;
  bit m_wrapped;
  bit m_halted;

  assign inc_value = inc_prev + 2'd1;
  assign inc_carry = &inc_prev;

  always #5 clk = ~clk;

  fetch_seq #(.PC_W(2), .INSTR_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .inc_prev   (inc_prev),
    .inc_value  (inc_value),
    .inc_carry  (inc_carry),
    .ovf_flag   (ovf_flag),
    .instr_out  (instr_out),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .wrapped    (wrapped),
    .halted     (halted)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag, input bit v_exp);
    chk({tag, "_valid"}, 32'(instr_valid), 32'(v_exp));
    chk({tag, "_addr"}, 32'(imem_addr), 32'(m_pc));
    chk({tag, "_prev"}, 32'(inc_prev), 32'(m_pc));
    chk({tag, "_wrapped"}, 32'(wrapped), 32'(m_wrapped));
    chk({tag, "_halted"}, 32'(halted), 32'(m_halted));
  endtask

  // Architectural effect of accepting one instruction.
  task automatic model_accept(input logic [7:0] instr, input bit ovf);
    int op;
    op = int'(instr[7:6]);
    if (op == 3) begin
      m_halted = 1'b1;
    end else if (op == 0 && !ovf) begin
      m_pc = int'(instr[1:0]);
    end else begin
      if (m_pc == 3) m_wrapped = 1'b1;
      m_pc = (m_pc + 1) % 4;
    end
  endtask

  task automatic model_reset();
    m_pc = 0;
    m_wrapped = 1'b0;
    m_halted = 1'b0;
  endtask

  // Expects the DUT to be in REQ on entry.
  task automatic fetch_one(input logic [7:0] instr, input int waits,
                           input int bp, input bit ovf);
    for (int i = 0; i < waits; i++) begin
      imem_valid = 1'b0;
      imem_rdata = 8'($urandom);
      instr_ready = 1'($urandom);
      step();
      chk_status("req_wait", 1'b0);
    end
    imem_valid = 1'b1;
    imem_rdata = instr;
    instr_ready = 1'($urandom);
    step();
    chk("cap_valid", 32'(instr_valid), 32'd1);
    chk("cap_instr", 32'(instr_out), 32'(instr));
    for (int i = 0; i < bp; i++) begin
      instr_ready = 1'b0;
      imem_valid = 1'($urandom);
      imem_rdata = 8'($urandom);
      ovf_flag = 1'($urandom);
      step();
      chk("hold_instr", 32'(instr_out), 32'(instr));
      chk_status("hold", 1'b1);
    end
    instr_ready = 1'b1;
    imem_valid = 1'($urandom);
    imem_rdata = 8'($urandom);
    ovf_flag = ovf;
    step();
    model_accept(instr, ovf);
    instr_ready = 1'b0;
    imem_valid = 1'b0;
    chk_status("accept", 1'b0);
  endtask

  task automatic start_run();
    run = 1'b1;
    step();
    run = 1'b0;
    chk_status("run", 1'b0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      run = 1'b0;
      imem_valid = 1'b1;
      imem_rdata = 8'($urandom);
      instr_ready = 1'($urandom);
      step();
      chk_status("idle", 1'b0);
    end
  endtask

  initial begin
    logic [7:0] w;
    model_reset();

    // reset held
    step();
    step();
    chk_status("rst", 1'b0);
    chk("rst_instr", 32'(instr_out), 32'd0);
    rst_n = 1'b1;
    idle_cycles(3);
    start_run();

    // sequential 0..3 with wrap on the addr-3 accept
    for (int a = 0; a < 4; a++) begin
      w = {2'b01, 6'($urandom)};
      fetch_one(w, 0, 0, 1'($urandom));
    end
    chk("seq_wrapped", 32'(wrapped), 32'd1);
    chk("seq_addr0", 32'(imem_addr), 32'd0);

    // async reset while holding an instruction
    imem_valid = 1'b1;
    imem_rdata = 8'h5a;
    step();
    chk("pre_rst_valid", 32'(instr_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk_status("async_rst", 1'b0);
    imem_valid = 1'b0;
    step();
    rst_n = 1'b1;
    idle_cycles(2);
    start_run();

    // JNO: taken, taken to 0, not taken
    fetch_one(8'b00_0000_10, 0, 0, 1'b0);
    chk("jno_taken_addr", 32'(imem_addr), 32'd2);
    fetch_one(8'b00_1010_00, 1, 0, 1'b0);
    chk("jno_zero_wrapped", 32'(wrapped), 32'd0);
    fetch_one(8'b00_0000_10, 0, 0, 1'b1);
    chk("jno_ovf_addr", 32'(imem_addr), 32'd1);

    // backpressure at PC=1
    fetch_one(8'b10_110011, 2, 4, 1'b0);
    chk("bp_addr", 32'(imem_addr), 32'd2);

    // random program without HLT
    for (int n = 0; n < 60; n++) begin
      w = {2'($urandom_range(2, 0)), 6'($urandom)};
      fetch_one(w, $urandom_range(2, 0), $urandom_range(3, 0),
                1'($urandom));
    end

    // jump to 1 then halt there
    fetch_one(8'b00_0000_01, 0, 0, 1'b0);
    fetch_one(8'b11_000000, 0, 1, 1'($urandom));
    chk("hlt_halted", 32'(halted), 32'd1);
    chk("hlt_addr", 32'(imem_addr), 32'd1);
    for (int i = 0; i < 6; i++) begin
      run = 1'($urandom);
      imem_valid = 1'($urandom);
      imem_rdata = 8'($urandom);
      instr_ready = 1'($urandom);
      ovf_flag = 1'($urandom);
      step();
      chk_status("halt", 1'b0);
      chk("halt_instr", 32'(instr_out), 32'h c0);
    end

    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk_status("final_rst", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_seq.md
# fetch_seq

Instruction-fetch sequencer for the 2-bit datapath CPU, sitting directly upstream of the PC incrementer stage. Holds the program counter and drives it to instruction memory and to the incrementer's previous-value input. Captures the fetched word and hands it downstream with a valid/ready handshake. On acceptance it loads either the incrementer's result or, for a taken JNO, the jump target; it also tracks PC wrap-around and halt.

## Interface
- PC_W, 2, program counter width; must match the incrementer width
- INSTR_W, 8, instruction word width; opcode is [INSTR_W-1:INSTR_W-2], target is [PC_W-1:0]

- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- run  in  1  start fetching; sampled only in IDLE
- imem_addr  out  PC_W  instruction memory address, equals PC (combinational)
- imem_rdata  in  INSTR_W  instruction memory read data
- imem_valid  in  1  imem_rdata valid this cycle
- inc_prev  out  PC_W  to incrementer prev_value, equals PC (combinational)
- inc_value  in  PC_W  incrementer result (PC+1 mod 2^PC_W)
- inc_carry  in  1  incrementer carry-out (sta)
- ovf_flag  in  1  ALU overflow flag, sampled at accept edge
- instr_out  out  INSTR_W  held instruction word
- instr_valid  out  1  instr_out valid
- instr_ready  in  1  downstream accepts instr_out
- wrapped  out  1  sticky: PC has wrapped from all-ones to zero
- halted  out  1  HLT executed; fetch stopped

## Operation
- Opcodes: 2'b00 JNO (jump if no overflow), 2'b11 HLT, 2'b01/2'b10 ordinary (sequential advance)
- States: IDLE, REQ, HOLD, HALT
- IDLE: instr_valid=0; run=1 at edge -> REQ; else stay
- REQ: address = PC; imem_valid=1 at edge -> capture imem_rdata into instr_out, -> HOLD; else stay
- HOLD: instr_valid=1, instr_out stable; imem_valid ignored; instr_valid&instr_ready at edge = accept
- On accept, by opcode of instr_out:
  - HLT: PC unchanged, halted<=1, -> HALT
  - JNO with ovf_flag=0: PC<=instr_out[PC_W-1:0]; wrapped unchanged; -> REQ
  - JNO with ovf_flag=1, or ordinary: PC<=inc_value; if inc_carry=1 then wrapped<=1; -> REQ
- HALT: instr_valid=0, all inputs ignored, PC frozen; left only by reset
- run is ignored outside IDLE; deassertion mid-program does not stop fetching
- Arithmetic done only by the incrementer; this block does no addition
- wrapped and halted are sticky until reset

## Timing
- Reset (async assert, any state): PC=0, state=IDLE, instr_out=0, instr_valid=0, wrapped=0, halted=0; imem_addr=inc_prev=0 immediately
- Reset mid-HOLD drops instr_valid asynchronously; the instruction is lost, not accepted
- Release: first possible transition is the first rising edge with rst_n=1
- imem_addr/inc_prev follow PC combinationally, same cycle as the PC update
- Minimum 2 cycles per instruction (REQ 1 cycle, HOLD 1 cycle); imem wait states add cycles in REQ, backpressure adds cycles in HOLD
- instr_valid rises on the edge that captures data; it falls on the accept edge (HLT or next REQ)
- inc_value/inc_carry/ovf_flag are sampled only at the accept edge
- PC=2^PC_W-1 sequential advance: PC->0, wrapped set on the same edge
- A taken JNO to any target never sets wrapped, including a jump to 0

## Test plan
- Reset/run: hold rst_n=0 -> all outputs 0; release, run=0 for 3 cycles -> stays IDLE, imem_addr=0; run=1 -> REQ next edge
- Sequential fetch, opcode 01 at addrs 0..3, imem_valid immediate, ready=1 -> instr_valid every 2nd cycle, imem_addr 0,1,2,3,0; wrapped=1 after the addr-3 accept
- JNO 8'b00_0000_10 at PC=0: ovf_flag=0 -> next imem_addr=2, wrapped=0; repeat with ovf_flag=1 -> next imem_addr=1
- Backpressure: instr_ready=0 for 4 cycles in HOLD, toggle imem_rdata/imem_valid -> instr_out stable, PC unchanged; ready=1 -> single accept, PC+1
- HLT 8'b11_000000 at PC=1 accepted -> halted=1, instr_valid=0, imem_addr stays 1 under run/imem_valid/ready activity
- Async reset asserted mid-HOLD between edges -> instr_valid, PC, wrapped, halted read 0 before the next edge
